// File: rtl/sdrc_bank_pkg.sv
// Shared state encoding and SDRAM command codes for the per-bank page controller.
package sdrc_bank_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StAct   = 3'd2,
        StXfr   = 3'd3,
        StClose = 3'd4,
        StTout  = 3'd5
    } bank_state_e;

    // OP_PRE is zero so an idle bank presents an all-zero command bus.
    localparam logic [1:0] OP_PRE = 2'b00;
    localparam logic [1:0] OP_ACT = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b11;

endpackage

// File: rtl/sdrc_bank_fsm_gen2_if.sv
// Request (r2b/b2r) and transfer-controller (b2x/x2b) signals of one bank controller.
interface sdrc_bank_fsm_gen2_if #(
    parameter int unsigned RA_W   = 13,
    parameter int unsigned CA_W   = 10,
    parameter int unsigned APP_RW = 9,
    parameter int unsigned ID_W   = 4
);
    logic              r2b_req;
    logic              r2b_start;
    logic              r2b_last;
    logic              r2b_wrap;
    logic              r2b_write;
    logic              r2b_close;
    logic [ID_W-1:0]   r2b_req_id;
    logic [RA_W-1:0]   r2b_raddr;
    logic [CA_W-1:0]   r2b_caddr;
    logic [APP_RW-1:0] r2b_len;
    logic              b2r_ack;

    logic              b2x_req;
    logic              b2x_start;
    logic              b2x_last;
    logic              b2x_wrap;
    logic [ID_W-1:0]   b2x_id;
    logic [RA_W-1:0]   b2x_addr;
    logic [APP_RW-1:0] b2x_len;
    logic [1:0]        b2x_cmd;
    logic              x2b_ack;
    logic              x2b_refresh;
    logic              x2b_pre_ok;
    logic              x2b_act_ok;
    logic              x2b_rdok;
    logic              x2b_wrok;
    logic              xfr_ok;

    // Bank controller side.
    modport slave (
        input  r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_close,
        input  r2b_req_id, r2b_raddr, r2b_caddr, r2b_len,
        output b2r_ack,
        output b2x_req, b2x_start, b2x_last, b2x_wrap, b2x_id, b2x_addr, b2x_len, b2x_cmd,
        input  x2b_ack, x2b_refresh, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok
    );

    // Request generator / transfer controller side.
    modport master (
        output r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_close,
        output r2b_req_id, r2b_raddr, r2b_caddr, r2b_len,
        input  b2r_ack,
        input  b2x_req, b2x_start, b2x_last, b2x_wrap, b2x_id, b2x_addr, b2x_len, b2x_cmd,
        output x2b_ack, x2b_refresh, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok
    );

endinterface

// File: rtl/sdrc_bank_timer.sv
// Load/decrement counter that saturates at zero; zero is the terminal-count flag.
module sdrc_bank_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sdrc_bank_fsm_gen2.sv
// Per-bank page controller: hit/miss detection, PRE/ACT/RD/WR issue with tRAS/tRP/tRCD.
// Define SDRC_PAGE_TIMEOUT_EN to close an idle open page after idle_timeout cycles.
module sdrc_bank_fsm_gen2
    import sdrc_bank_pkg::*;
#(
    parameter int unsigned RA_W   = 13,
    parameter int unsigned CA_W   = 10,
    parameter int unsigned APP_RW = 9,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned TMR_W  = 4,
    parameter int unsigned IDLE_W = 8,
    parameter int unsigned AP_BIT = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    sdrc_bank_fsm_gen2_if.slave bus,
    input  logic [TMR_W-1:0]   tras_delay,
    input  logic [TMR_W-1:0]   trp_delay,
    input  logic [TMR_W-1:0]   trcd_delay,
    input  logic [IDLE_W-1:0]  idle_timeout,
    output logic               tras_ok,
    output logic               bank_open,
    output logic [RA_W-1:0]    bank_row
);

    localparam logic [RA_W-1:0] AP_MASK = ~({{(RA_W-1){1'b0}}, 1'b1} << AP_BIT);

    bank_state_e       state_q, state_d;
    logic              bank_open_q, bank_open_d;
    logic [RA_W-1:0]   bank_row_q;
    logic              lat_write_q, lat_close_q, lat_start_q, lat_last_q, lat_wrap_q;
    logic [ID_W-1:0]   lat_id_q;
    logic [RA_W-1:0]   lat_raddr_q;
    logic [CA_W-1:0]   lat_caddr_q;
    logic [APP_RW-1:0] lat_len_q;

    logic              req, ack, fire, act_fire, pre_fire, drop_page;
    logic [1:0]        cmd;
    logic [RA_W-1:0]   addr;
    logic              t0_tc, hit, in_idle, latch_en, idle_expired;

    assign in_idle  = (state_q == StIdle);
    assign hit      = bank_open_q && (bus.r2b_raddr == bank_row_q);
    assign latch_en = in_idle && bus.r2b_req;

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        ack     = 1'b0;
        cmd     = OP_PRE;
        addr    = '0;
        case (state_q)
            StIdle: begin
                if (bus.r2b_req) begin
                    ack = 1'b1;
                    if (hit) begin
                        cmd  = bus.r2b_write ? OP_WR : OP_RD;
                        addr = RA_W'(bus.r2b_caddr);
                        req  = (bus.r2b_write ? bus.x2b_wrok : bus.x2b_rdok) && bus.xfr_ok;
                        if (req && bus.x2b_ack) begin
                            state_d = bus.r2b_close ? StClose : StIdle;
                        end else begin
                            state_d = StXfr;
                        end
                    end else if (bank_open_q) begin
                        cmd     = OP_PRE;
                        addr    = bus.r2b_raddr & AP_MASK;
                        req     = tras_ok && bus.x2b_pre_ok;
                        state_d = (req && bus.x2b_ack) ? StAct : StPre;
                    end else begin
                        // Closed bank: no PRE needed, activate straight away.
                        cmd     = OP_ACT;
                        addr    = bus.r2b_raddr;
                        req     = t0_tc && bus.x2b_act_ok;
                        state_d = (req && bus.x2b_ack) ? StXfr : StAct;
                    end
                end else if (idle_expired) begin
                    state_d = StTout;
                end
            end
            StPre: begin
                cmd  = OP_PRE;
                addr = lat_raddr_q & AP_MASK;
                req  = tras_ok && bus.x2b_pre_ok;
                if (req && bus.x2b_ack) state_d = StAct;
            end
            StAct: begin
                cmd  = OP_ACT;
                addr = lat_raddr_q;
                req  = t0_tc && bus.x2b_act_ok;
                if (req && bus.x2b_ack) state_d = StXfr;
            end
            StXfr: begin
                cmd  = lat_write_q ? OP_WR : OP_RD;
                addr = RA_W'(lat_caddr_q);
                req  = t0_tc && (lat_write_q ? bus.x2b_wrok : bus.x2b_rdok) && bus.xfr_ok;
                // A refresh closed the row under us: reopen it before retrying.
                if (bus.x2b_refresh) begin
                    state_d = StAct;
                end else if (req && bus.x2b_ack) begin
                    state_d = lat_close_q ? StClose : StIdle;
                end
            end
            StClose: begin
                cmd  = OP_PRE;
                addr = lat_raddr_q & AP_MASK;
                req  = tras_ok && bus.x2b_pre_ok;
                if (req && bus.x2b_ack) state_d = StIdle;
            end
            StTout: begin
                cmd  = OP_PRE;
                addr = bank_row_q & AP_MASK;
                req  = tras_ok && bus.x2b_pre_ok;
                if (req && bus.x2b_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign fire      = req && bus.x2b_ack;
    assign act_fire  = fire && (cmd == OP_ACT);
    assign pre_fire  = fire && (cmd == OP_PRE);
    assign drop_page = fire && ((state_q == StClose) || (state_q == StTout));

    always_comb begin
        bank_open_d = bank_open_q;
        if (act_fire) bank_open_d = 1'b1;
        if (bus.x2b_refresh || drop_page) bank_open_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            bank_open_q <= 1'b0;
            bank_row_q  <= '0;
            lat_write_q <= 1'b0;
            lat_close_q <= 1'b0;
            lat_start_q <= 1'b0;
            lat_last_q  <= 1'b0;
            lat_wrap_q  <= 1'b0;
            lat_id_q    <= '0;
            lat_raddr_q <= '0;
            lat_caddr_q <= '0;
            lat_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            bank_open_q <= bank_open_d;
            if (act_fire) bank_row_q <= addr;
            if (latch_en) begin
                lat_write_q <= bus.r2b_write;
                lat_close_q <= bus.r2b_close;
                lat_start_q <= bus.r2b_start;
                lat_last_q  <= bus.r2b_last;
                lat_wrap_q  <= bus.r2b_wrap;
                lat_id_q    <= bus.r2b_req_id;
                lat_raddr_q <= bus.r2b_raddr;
                lat_caddr_q <= bus.r2b_caddr;
                lat_len_q   <= bus.r2b_len;
            end
        end
    end

    sdrc_bank_timer #(.W(TMR_W)) u_tras (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (act_fire),
        .load_val (tras_delay),
        .dec      (1'b1),
        .zero     (tras_ok)
    );

    sdrc_bank_timer #(.W(TMR_W)) u_timer0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (pre_fire || act_fire),
        .load_val (act_fire ? trcd_delay : trp_delay),
        .dec      (1'b1),
        .zero     (t0_tc)
    );

`ifdef SDRC_PAGE_TIMEOUT_EN
    logic idle_cnt_en, idle_zero;

    assign idle_cnt_en = in_idle && bank_open_q && !bus.r2b_req;

    // Down-counts from idle_timeout; reaching zero equals an up-count hitting the limit.
    sdrc_bank_timer #(.W(IDLE_W)) u_idle (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (!idle_cnt_en),
        .load_val (idle_timeout),
        .dec      (idle_cnt_en),
        .zero     (idle_zero)
    );

    assign idle_expired = idle_cnt_en && idle_zero && (idle_timeout != '0);
`else
    logic unused_idle;
    assign unused_idle  = ^idle_timeout;
    assign idle_expired = 1'b0;
`endif

    assign bus.b2r_ack   = ack;
    assign bus.b2x_req   = req;
    assign bus.b2x_cmd   = cmd;
    assign bus.b2x_addr  = addr;
    assign bus.b2x_start = in_idle ? bus.r2b_start  : lat_start_q;
    assign bus.b2x_last  = in_idle ? bus.r2b_last   : lat_last_q;
    assign bus.b2x_wrap  = in_idle ? bus.r2b_wrap   : lat_wrap_q;
    assign bus.b2x_id    = in_idle ? bus.r2b_req_id : lat_id_q;
    assign bus.b2x_len   = in_idle ? bus.r2b_len    : lat_len_q;
    assign bank_open     = bank_open_q;
    assign bank_row      = bank_row_q;

endmodule

// File: tb/tb_sdrc_bank_fsm_gen2.sv
// Directed bench for sdrc_bank_fsm_gen2: closed/open miss, hit, close-page, refresh, timeout.
module tb_sdrc_bank_fsm_gen2;
    import sdrc_bank_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [3:0] tras_delay, trp_delay, trcd_delay;
    logic [7:0] idle_timeout;
    logic       tras_ok, bank_open;
    logic [12:0] bank_row;
    int n_tests = 0;
    int n_fail  = 0;

    sdrc_bank_fsm_gen2_if bus ();

    sdrc_bank_fsm_gen2 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .tras_delay   (tras_delay),
        .trp_delay    (trp_delay),
        .trcd_delay   (trcd_delay),
        .idle_timeout (idle_timeout),
        .tras_ok      (tras_ok),
        .bank_open    (bank_open),
        .bank_row     (bank_row)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [12:0] row, input logic [9:0] col,
                         input logic cls);
        bus.r2b_req   = 1'b1;
        bus.r2b_write = wr;
        bus.r2b_raddr = row;
        bus.r2b_caddr = col;
        bus.r2b_close = cls;
    endtask

    // Counts cycles until b2x_req rises (request is withdrawn after its first cycle).
    task automatic run_until_req(input string tag, input int exp_wait, input logic [1:0] exp_cmd,
                                 input logic [12:0] exp_addr);
        int n = 0;
        #1;
        while (bus.b2x_req !== 1'b1 && n < 60) begin
            @(negedge clk);
            bus.r2b_req = 1'b0;
            #1;
            n++;
        end
        check({tag, "_wait"}, 32'(n), 32'(exp_wait));
        check({tag, "_cmd"}, 32'(bus.b2x_cmd), 32'(exp_cmd));
        check({tag, "_addr"}, 32'(bus.b2x_addr), 32'(exp_addr));
    endtask

    task automatic accept();
        @(negedge clk);
        bus.r2b_req   = 1'b0;
        bus.r2b_close = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        tras_delay      = 4'd5;
        trp_delay       = 4'd2;
        trcd_delay      = 4'd3;
        idle_timeout    = 8'd20;
        bus.r2b_req     = 1'b0;
        bus.r2b_start   = 1'b1;
        bus.r2b_last    = 1'b1;
        bus.r2b_wrap    = 1'b0;
        bus.r2b_write   = 1'b0;
        bus.r2b_close   = 1'b0;
        bus.r2b_req_id  = 4'd0;
        bus.r2b_raddr   = '0;
        bus.r2b_caddr   = '0;
        bus.r2b_len     = '0;
        bus.x2b_ack     = 1'b1;
        bus.x2b_refresh = 1'b0;
        bus.x2b_pre_ok  = 1'b1;
        bus.x2b_act_ok  = 1'b1;
        bus.x2b_rdok    = 1'b1;
        bus.x2b_wrok    = 1'b1;
        bus.xfr_ok      = 1'b1;

        @(negedge clk);
        #1;
        check("rst_bank_open", 32'(bank_open), 32'd0);
        check("rst_bank_row", 32'(bank_row), 32'd0);
        check("rst_tras_ok", 32'(tras_ok), 32'd1);
        check("rst_b2x_req", 32'(bus.b2x_req), 32'd0);
        check("rst_b2x_cmd", 32'(bus.b2x_cmd), 32'd0);
        check("rst_b2x_addr", 32'(bus.b2x_addr), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Closed-bank miss: ACT immediately, RD after trcd_delay idle cycles.
        bus.r2b_req_id = 4'd3;
        bus.r2b_len    = 9'd8;
        issue(1'b0, 13'h123, 10'h045, 1'b0);
        #1;
        check("t1_b2r_ack", 32'(bus.b2r_ack), 32'd1);
        check("t1_id_idle", 32'(bus.b2x_id), 32'd3);
        run_until_req("t1_act", 0, OP_ACT, 13'h123);
        accept();
        bus.r2b_req_id = 4'd9;
        bus.r2b_len    = 9'd1;
        run_until_req("t1_rd", 3, OP_RD, 13'h045);
        check("t1_id_lat", 32'(bus.b2x_id), 32'd3);
        check("t1_len_lat", 32'(bus.b2x_len), 32'd8);
        check("t1_bank_open", 32'(bank_open), 32'd1);
        check("t1_bank_row", 32'(bank_row), 32'h123);
        accept();

        // Open-bank miss: PRE waits for tRAS, ACT follows after trp_delay.
        issue(1'b1, 13'h200, 10'h010, 1'b0);
        run_until_req("t2_pre", 1, OP_PRE, 13'h200);
        accept();
        run_until_req("t2_act", 2, OP_ACT, 13'h200);
        accept();
        run_until_req("t2_wr", 3, OP_WR, 13'h010);
        accept();

        // Page hit: WR in the same cycle as the ack, bank stays in IDLE.
        issue(1'b1, 13'h200, 10'h020, 1'b0);
        #1;
        check("t3_b2r_ack", 32'(bus.b2r_ack), 32'd1);
        run_until_req("t3_wr", 0, OP_WR, 13'h020);
        accept();
        #1;
        check("t3_idle_req", 32'(bus.b2x_req), 32'd0);
        check("t3_idle_cmd", 32'(bus.b2x_cmd), 32'd0);
        check("t3_idle_addr", 32'(bus.b2x_addr), 32'd0);
        check("t3_idle_ack", 32'(bus.b2r_ack), 32'd0);
        @(negedge clk);

        // Close-page: RD hit, then PRE; the next access to the same row re-activates.
        issue(1'b0, 13'h200, 10'h030, 1'b1);
        run_until_req("t4_rd", 0, OP_RD, 13'h030);
        accept();
        run_until_req("t4_pre", 0, OP_PRE, 13'h200);
        accept();
        #1;
        check("t4_bank_open", 32'(bank_open), 32'd0);
        issue(1'b0, 13'h200, 10'h031, 1'b0);
        run_until_req("t4_act", 2, OP_ACT, 13'h200);
        accept();

        // Refresh while waiting in XFR: re-ACT, then finish the read.
        bus.x2b_ack     = 1'b0;
        bus.x2b_refresh = 1'b1;
        @(negedge clk);
        bus.x2b_refresh = 1'b0;
        bus.x2b_ack     = 1'b1;
        #1;
        check("t5_open_cleared", 32'(bank_open), 32'd0);
        run_until_req("t5_act", 2, OP_ACT, 13'h200);
        accept();
        run_until_req("t5_rd", 3, OP_RD, 13'h031);
        check("t5_bank_open", 32'(bank_open), 32'd1);
        accept();

        // Miss to a row with bit 10 set: PRE address has it cleared, ACT keeps it.
        issue(1'b0, 13'h4A5, 10'h3FF, 1'b0);
        run_until_req("t6_pre", 1, OP_PRE, 13'h0A5);
        accept();
        run_until_req("t6_act", 2, OP_ACT, 13'h4A5);
        accept();
        run_until_req("t6_rd", 3, OP_RD, 13'h3FF);
        accept();
        check("t6_bank_row", 32'(bank_row), 32'h4A5);

`ifdef SDRC_PAGE_TIMEOUT_EN
        // Idle timeout: 21 quiet cycles then PRE; a request during TOUT waits for it.
        bus.x2b_ack = 1'b0;
        run_until_req("t7_tout_pre", 21, OP_PRE, 13'h0A5);
        issue(1'b0, 13'h4A5, 10'h001, 1'b0);
        #1;
        check("t7_tout_no_ack", 32'(bus.b2r_ack), 32'd0);
        bus.x2b_ack = 1'b1;
        @(negedge clk);
        #1;
        check("t7_bank_open", 32'(bank_open), 32'd0);
        check("t7_late_ack", 32'(bus.b2r_ack), 32'd1);
        run_until_req("t7_act", 2, OP_ACT, 13'h4A5);
        accept();
        run_until_req("t7_rd", 3, OP_RD, 13'h001);
        accept();
`else
        // Without the timeout the page stays open indefinitely.
        repeat (30) @(negedge clk);
        #1;
        check("t7_still_open", 32'(bank_open), 32'd1);
        check("t7_idle_req", 32'(bus.b2x_req), 32'd0);
        @(negedge clk);
`endif

        // Asynchronous reset while a PRE is pending wipes all state.
        bus.x2b_ack = 1'b0;
        issue(1'b0, 13'h111, 10'h002, 1'b0);
        @(negedge clk);
        bus.r2b_req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("t8_rst_open", 32'(bank_open), 32'd0);
        check("t8_rst_row", 32'(bank_row), 32'd0);
        check("t8_rst_tras_ok", 32'(tras_ok), 32'd1);
        check("t8_rst_req", 32'(bus.b2x_req), 32'd0);
        @(negedge clk);
        reset_n     = 1'b1;
        bus.x2b_ack = 1'b1;
        @(negedge clk);
        issue(1'b0, 13'h111, 10'h002, 1'b0);
        run_until_req("t8_act", 0, OP_ACT, 13'h111);
        accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
